// File: rtl/yarp_pkg.sv
// Shared types for the yarp load/store path.
package yarp_pkg;

    localparam int unsigned XLEN = 32;

    // Access size as encoded by execute; 3 is reserved and always faults.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/yarp_lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store replication,
// load extraction/extension and alignment check. Purely combinational.
module yarp_lsu_align
    import yarp_pkg::*;
(
    input  mem_size_t         i_size,
    input  logic              i_zero_ext,
    input  logic [1:0]        i_offset,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [3:0]        o_be,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_misalign
);

    logic [XLEN-1:0] w_shift;

    // Addressed byte moved down to lane 0.
    assign w_shift = i_rdata >> {i_offset, 3'b000};

    // Decode size into lane enables, replicated store data and extended load data.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = w_shift;
        o_misalign = 1'b0;
        case (i_size)
            MEM_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_zero_ext ? {24'b0, w_shift[7:0]}
                                     : {{24{w_shift[7]}}, w_shift[7:0]};
            end
            MEM_HALF: begin
                o_misalign = i_offset[0];
                o_be       = 4'b0011 << i_offset;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = i_zero_ext ? {16'b0, w_shift[15:0]}
                                        : {{16{w_shift[15]}}, w_shift[15:0]};
            end
            MEM_WORD: begin
                o_misalign = |i_offset;
                o_be       = 4'hF;
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/yarp_lsu.sv
// Load/store unit: one op at a time from execute to a gnt/rvalid data bus,
// with registered writeback and one-cycle misalign / bus-error flags.
module yarp_lsu
    import yarp_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_store_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_zero_ext_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              dmem_req_o,
    input  logic              dmem_gnt_i,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    input  logic              dmem_err_i,
    output logic              wb_en_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              busy_o
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    lsu_state_t      r_state, w_state_next;
    logic            r_store, r_zext;
    mem_size_t       r_size;
    logic [XLEN-1:0] r_addr, r_wdata;
    logic [4:0]      r_rd;
    logic [7:0]      r_cnt;
    logic            r_wb_en, r_misalign, r_bus_err;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_idle, w_accept, w_resp, w_timeout, w_misalign;
    mem_size_t       w_al_size;
    logic [1:0]      w_al_offset;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata, w_ldata;

    assign w_idle = (r_state == StIdle);

    // In IDLE the aligner checks the incoming request; otherwise it serves the captured op.
    assign w_al_size   = w_idle ? mem_size_t'(req_size_i) : r_size;
    assign w_al_offset = w_idle ? req_addr_i[1:0] : r_addr[1:0];

    yarp_lsu_align u_align (
        .i_size     (w_al_size),
        .i_zero_ext (r_zext),
        .i_offset   (w_al_offset),
        .i_wdata    (r_wdata),
        .i_rdata    (dmem_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ldata),
        .o_misalign (w_misalign)
    );

    assign w_accept  = w_idle && req_valid_i && !w_misalign;
    assign w_resp    = ((r_state == StReq) && dmem_gnt_i && dmem_rvalid_i) ||
                       ((r_state == StWait) && dmem_rvalid_i);
    // A response arriving on the last allowed cycle still wins over the timeout.
    assign w_timeout = !w_idle && !w_resp && (r_cnt == LP_MAX_WAIT);

    assign req_ready_o  = w_idle;
    assign busy_o       = !w_idle;
    assign dmem_req_o   = (r_state == StReq);
    assign dmem_we_o    = dmem_req_o && r_store;
    assign dmem_be_o    = dmem_req_o ? w_be : 4'b0000;
    assign dmem_addr_o  = dmem_req_o ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata_o = dmem_req_o ? w_wdata : '0;
    assign wb_en_o      = r_wb_en;
    assign wb_rd_o      = r_wb_rd;
    assign wb_data_o    = r_wb_data;
    assign misalign_o   = r_misalign;
    assign bus_err_o    = r_bus_err;

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (w_accept) w_state_next = StReq;
            StReq: begin
                if (w_resp || w_timeout) w_state_next = StIdle;
                else if (dmem_gnt_i)     w_state_next = StWait;
            end
            StWait: if (w_resp || w_timeout) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    // Capture the accepted op; it stays stable until the next acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_store <= 1'b0;
            r_zext  <= 1'b0;
            r_size  <= MEM_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 5'd0;
        end else if (w_accept) begin
            r_store <= req_store_i;
            r_zext  <= req_zero_ext_i;
            r_size  <= mem_size_t'(req_size_i);
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_rd    <= req_rd_i;
        end
    end

    // Timeout counter: zero while idle, counts every cycle of an outstanding op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_cnt <= 8'd0;
        else if (w_idle) r_cnt <= 8'd0;
        else             r_cnt <= r_cnt + 8'd1;
    end

    // Writeback and one-cycle flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_en    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wb_en    <= w_resp && !dmem_err_i && !r_store && (r_rd != 5'd0);
            r_misalign <= w_idle && req_valid_i && w_misalign;
            r_bus_err  <= (w_resp && dmem_err_i) || w_timeout;
            if (w_resp) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_ldata;
            end
        end
    end

endmodule

// File: tb/tb_yarp_lsu.sv
// Self-checking bench for yarp_lsu with a writeback scoreboard.
module tb_yarp_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid_i, req_ready_o, req_store_i, req_zero_ext_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_rvalid_i, dmem_err_i;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic        wb_en_o, misalign_o, bus_err_o, busy_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_misalign = 0;
    int  n_buserr   = 0;

    always #5 clk = ~clk;

    yarp_lsu #(.MAX_WAIT(4)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_store_i    (req_store_i),
        .req_size_i     (req_size_i),
        .req_zero_ext_i (req_zero_ext_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_rd_i       (req_rd_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_we_o      (dmem_we_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_err_i     (dmem_err_i),
        .wb_en_o        (wb_en_o),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o),
        .misalign_o     (misalign_o),
        .bus_err_o      (bus_err_o),
        .busy_o         (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Writeback monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n) begin
            if (misalign_o) n_misalign++;
            if (bus_err_o)  n_buserr++;
            if (wb_en_o) begin
                if (sb_q.size() == 0) begin
                    check_eq("wb_unexpected", 32'(wb_en_o), 32'd0);
                end else begin
                    wb_t e;
                    e = sb_q.pop_front();
                    check_eq("wb_rd", 32'(wb_rd_o), 32'(e.rd));
                    check_eq("wb_data", wb_data_o, e.data);
                end
            end
        end
    end

    task automatic present(input bit st, input logic [1:0] sz, input bit zx,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd);
        check_eq("ready_before", 32'(req_ready_o), 32'd1);
        req_valid_i    = 1'b1;
        req_store_i    = st;
        req_size_i     = sz;
        req_zero_ext_i = zx;
        req_addr_i     = addr;
        req_wdata_i    = wd;
        req_rd_i       = rd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    // One full bus op. rv_dly = 0 means rvalid coincides with gnt.
    task automatic do_op(input bit st, input logic [1:0] sz, input bit zx,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata, input bit err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_wb);
        int  b0;
        bit  wb_exp;
        b0     = n_buserr;
        wb_exp = !st && (rd != 5'd0) && !err;
        present(st, sz, zx, addr, wd, rd);
        check_eq("dmem_req", 32'(dmem_req_o), 32'd1);
        check_eq("busy", 32'(busy_o), 32'd1);
        check_eq("dmem_be", 32'(dmem_be_o), 32'(exp_be));
        check_eq("dmem_addr", dmem_addr_o, {addr[31:2], 2'b00});
        check_eq("dmem_we", 32'(dmem_we_o), 32'(st));
        if (st) check_eq("dmem_wdata", dmem_wdata_o, exp_wdata);
        for (int i = 0; i < gnt_dly; i++) begin
            @(posedge clk); #1;
            check_eq("req_hold", 32'(dmem_req_o), 32'd1);
        end
        if (wb_exp) sb_q.push_back('{rd: rd, data: exp_wb});
        dmem_gnt_i = 1'b1;
        if (rv_dly == 0) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
            dmem_err_i    = err;
        end
        @(posedge clk); #1;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_err_i    = 1'b0;
        if (rv_dly > 0) begin
            check_eq("req_drop", 32'(dmem_req_o), 32'd0);
            for (int i = 1; i < rv_dly; i++) begin
                @(posedge clk); #1;
            end
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
            dmem_err_i    = err;
            @(posedge clk); #1;
            dmem_rvalid_i = 1'b0;
            dmem_err_i    = 1'b0;
        end
        check_eq("wb_en_latency", 32'(wb_en_o), 32'(wb_exp));
        check_eq("bus_err_flag", 32'(bus_err_o), 32'(err));
        check_eq("idle_after", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        check_eq("wb_one_cycle", 32'(wb_en_o), 32'd0);
        check_eq("bus_err_pulses", 32'(n_buserr - b0), 32'(err));
    endtask

    task automatic do_misalign(input logic [1:0] sz, input logic [31:0] addr);
        int m0;
        m0 = n_misalign;
        present(1'b0, sz, 1'b0, addr, 32'd0, 5'd3);
        check_eq("misalign_flag", 32'(misalign_o), 32'd1);
        check_eq("misalign_noreq", 32'(dmem_req_o), 32'd0);
        check_eq("misalign_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        check_eq("misalign_pulse", 32'(misalign_o), 32'd0);
        check_eq("misalign_count", 32'(n_misalign - m0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;
        int  b0;
        reset_n = 1'b0;
        req_valid_i = 1'b0; req_store_i = 1'b0; req_size_i = 2'd0; req_zero_ext_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; dmem_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(req_ready_o), 32'd1);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_dmem_req", 32'(dmem_req_o), 32'd0);
        check_eq("rst_be", 32'(dmem_be_o), 32'd0);
        check_eq("rst_wb_en", 32'(wb_en_o), 32'd0);
        check_eq("rst_wb_data", wb_data_o, 32'd0);
        check_eq("rst_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Loads: LW, LB/LBU, LH/LHU
        do_op(0, 2'd2, 0, 32'h100, 0, 5'd5, 2, 1, 32'hDEADBEEF, 0, 4'hF, 0, 32'hDEADBEEF);
        do_op(0, 2'd0, 0, 32'h203, 0, 5'd6, 0, 0, 32'h80000000, 0, 4'h8, 0, 32'hFFFFFF80);
        do_op(0, 2'd0, 1, 32'h203, 0, 5'd6, 1, 2, 32'h80000000, 0, 4'h8, 0, 32'h00000080);
        do_op(0, 2'd1, 0, 32'h302, 0, 5'd7, 0, 1, 32'hF2345678, 0, 4'hC, 0, 32'hFFFFF234);
        do_op(0, 2'd1, 1, 32'h302, 0, 5'd7, 0, 0, 32'hF2345678, 0, 4'hC, 0, 32'h0000F234);
        do_op(0, 2'd0, 0, 32'h401, 0, 5'd8, 0, 0, 32'h00007F00, 0, 4'h2, 0, 32'h0000007F);
        // Stores: no writeback expected
        do_op(1, 2'd1, 0, 32'h102, 32'h0000ABCD, 5'd0, 1, 1, 0, 0, 4'hC, 32'hABCDABCD, 0);
        do_op(1, 2'd0, 0, 32'h101, 32'h0000005A, 5'd0, 0, 1, 0, 0, 4'h2, 32'h5A5A5A5A, 0);
        do_op(1, 2'd2, 0, 32'h104, 32'h12345678, 5'd0, 0, 0, 0, 0, 4'hF, 32'h12345678, 0);

        // Alignment faults
        do_misalign(2'd2, 32'h101);
        do_misalign(2'd1, 32'h103);
        do_misalign(2'd3, 32'h100);

        // Timeout: gnt given, rvalid withheld
        b0 = n_buserr;
        present(0, 2'd2, 0, 32'h80, 0, 5'd11);
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            if (bus_err_o) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        check_eq("timeout_flag", 32'(seen), 32'd1);
        check_eq("timeout_not_early", 32'(k >= 2), 32'd1);
        check_eq("timeout_idle", 32'(busy_o), 32'd0);
        check_eq("timeout_req_low", 32'(dmem_req_o), 32'd0);
        @(posedge clk); #1;
        check_eq("timeout_pulses", 32'(n_buserr - b0), 32'd1);

        do_op(0, 2'd2, 0, 32'h10, 0, 5'd12, 1, 1, 32'hCAFEF00D, 0, 4'hF, 0, 32'hCAFEF00D);
        // LW x0 and a bus error: neither writes back
        do_op(0, 2'd2, 0, 32'h20, 0, 5'd0, 0, 1, 32'h11111111, 0, 4'hF, 0, 0);
        do_op(0, 2'd2, 0, 32'h24, 0, 5'd9, 1, 1, 32'h22222222, 1, 4'hF, 0, 0);

        // Reset while waiting for rvalid cancels the op
        present(0, 2'd2, 0, 32'h40, 0, 5'd10);
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        check_eq("midrst_busy_before", 32'(busy_o), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy_o), 32'd0);
        check_eq("midrst_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h33333333;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        check_eq("midrst_no_wb", 32'(wb_en_o), 32'd0);
        check_eq("midrst_no_err", 32'(bus_err_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
